// File: rtl/fpga_io_pkg.sv
// Shared definitions for the fabric I/O conditioners (GPIN input side and
// io_output side): filter FSM state encoding and default sizing constants.
package fpga_io_pkg;

  // Debounce filter FSM encoding.
  typedef enum logic {
    GPIN_ST_STABLE  = 1'b0,
    GPIN_ST_QUALIFY = 1'b1
  } gpin_state_e;

  // Default synchronizer depth and debounce counter width.
  localparam int GPIN_SYNC_STAGES_DEF = 2;
  localparam int GPIN_CNT_W_DEF       = 8;

endpackage

// File: rtl/gpin_input_conditioner_if.sv
// Pad-side bundle of the GPIN input conditioner: raw levels and filter
// configuration in, conditioned levels and edge pulses out.
interface gpin_input_conditioner_if #(
  parameter int NUM_PADS = 8,
  parameter int CNT_W    = 8
);

  logic [NUM_PADS-1:0] gpin_raw;
  logic                cfg_filter_en;
  logic [CNT_W-1:0]    cfg_stable_cycles;
  logic [NUM_PADS-1:0] gpin_clean;
  logic [NUM_PADS-1:0] gpin_rise;
  logic [NUM_PADS-1:0] gpin_fall;

  modport master (
    output gpin_raw,
    output cfg_filter_en,
    output cfg_stable_cycles,
    input  gpin_clean,
    input  gpin_rise,
    input  gpin_fall
  );

  modport slave (
    input  gpin_raw,
    input  cfg_filter_en,
    input  cfg_stable_cycles,
    output gpin_clean,
    output gpin_rise,
    output gpin_fall
  );

endinterface

// File: rtl/gpin_filter_channel.sv
// One GPIN channel: flop synchronizer, debounce FSM with qualify counter,
// and registered rise/fall pulses aligned with the conditioned level.
//
// state           | meaning
// ----------------+-----------------------------------------------------
// GPIN_ST_STABLE  | synchronized level equals clean output, counter 0
// GPIN_ST_QUALIFY | level differs, counting consecutive differing cycles
module gpin_filter_channel
  import fpga_io_pkg::*;
#(
  parameter int   SYNC_STAGES = GPIN_SYNC_STAGES_DEF,
  parameter int   CNT_W       = GPIN_CNT_W_DEF,
  parameter logic RESET_BIT   = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pad_raw,
  input  logic             cfg_filter_en,
  input  logic [CNT_W-1:0] cfg_stable_cycles,
  output logic             clean,
  output logic             rise,
  output logic             fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  gpin_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       n_eff;
  logic                   clean_q, clean_d;
  logic                   rise_q, fall_q;
  logic                   mismatch;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign mismatch = (sync_lvl != clean_q);
  // A programmed count of zero means "accept on first differing cycle".
  assign n_eff    = (cfg_stable_cycles == '0) ? CNT_W'(1) : cfg_stable_cycles;

  // Synchronizer chain: pure flop-to-flop shift, nothing between stages.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_BIT}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_raw};
    end
  end

  // Next-state, counter and output level decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (!cfg_filter_en) begin
      state_d = GPIN_ST_STABLE;
      cnt_d   = '0;
      clean_d = sync_lvl;
    end else begin
      case (state_q)
        GPIN_ST_STABLE: begin
          if (mismatch) begin
            if (n_eff == CNT_W'(1)) begin
              clean_d = sync_lvl;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = GPIN_ST_QUALIFY;
            end
          end
        end
        GPIN_ST_QUALIFY: begin
          if (!mismatch) begin
            cnt_d   = '0;
            state_d = GPIN_ST_STABLE;
          end else if (cnt_q >= n_eff - CNT_W'(1)) begin
            // >= so that lowering the threshold mid-count finishes promptly.
            clean_d = sync_lvl;
            cnt_d   = '0;
            state_d = GPIN_ST_STABLE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = GPIN_ST_STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter, level and edge-pulse registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= GPIN_ST_STABLE;
      cnt_q   <= '0;
      clean_q <= RESET_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= clean_d & ~clean_q;
      fall_q  <= ~clean_d & clean_q;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/gpin_input_conditioner.sv
// GPIN input conditioner: NUM_PADS independent synchronize-and-debounce
// channels feeding the io_input tile pads, sharing clock, reset and config.
module gpin_input_conditioner
  import fpga_io_pkg::*;
#(
  parameter int                  NUM_PADS    = 8,
  parameter int                  SYNC_STAGES = GPIN_SYNC_STAGES_DEF,
  parameter int                  CNT_W       = GPIN_CNT_W_DEF,
  parameter logic [NUM_PADS-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  gpin_input_conditioner_if.slave gpin_bus
);

  logic [NUM_PADS-1:0] clean_vec;
  logic [NUM_PADS-1:0] rise_vec;
  logic [NUM_PADS-1:0] fall_vec;

  // One filter channel per pad, each with its own reset level.
  for (genvar i = 0; i < NUM_PADS; i++) begin : g_chan
    gpin_filter_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RESET_BIT   (RESET_VALUE[i])
    ) u_chan (
      .clk               (clk),
      .reset_n           (reset_n),
      .pad_raw           (gpin_bus.gpin_raw[i]),
      .cfg_filter_en     (gpin_bus.cfg_filter_en),
      .cfg_stable_cycles (gpin_bus.cfg_stable_cycles),
      .clean             (clean_vec[i]),
      .rise              (rise_vec[i]),
      .fall              (fall_vec[i])
    );
  end

  assign gpin_bus.gpin_clean = clean_vec;
  assign gpin_bus.gpin_rise  = rise_vec;
  assign gpin_bus.gpin_fall  = fall_vec;

endmodule

// File: tb/tb_gpin_input_conditioner.sv
// Directed bench for gpin_input_conditioner (8 pads, 2 sync stages,
// reset value 8'hA5). Inputs change 1 ns after a rising edge; outputs are
// sampled at the same point, so "edge k" means k rising edges after the change.
module tb_gpin_input_conditioner;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  gpin_input_conditioner_if #(.NUM_PADS(8), .CNT_W(8)) bus ();

  gpin_input_conditioner #(
    .NUM_PADS    (8),
    .SYNC_STAGES (2),
    .CNT_W       (8),
    .RESET_VALUE (8'hA5)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .gpin_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.gpin_raw          = 8'h00;
    bus.cfg_filter_en     = 1'b1;
    bus.cfg_stable_cycles = 8'd5;

    // Reset held for 3 edges with raw pads low.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_clean", 16'(bus.gpin_clean), 16'h00A5);
      chk("rst_edges", {bus.gpin_rise, bus.gpin_fall}, 16'h0000);
    end
    bus.gpin_raw = 8'hA5;
    reset_n = 1'b1;
    repeat (4) step();
    chk("post_rst_clean", 16'(bus.gpin_clean), 16'h00A5);

    // Bypass latency: raw[0] 0->1 appears at edge 3.
    bus.cfg_filter_en = 1'b0;
    bus.gpin_raw = 8'hA4;
    repeat (4) step();
    chk("byp_setup", 16'(bus.gpin_clean), 16'h00A4);
    bus.gpin_raw = 8'hA5;
    step();
    chk("byp_e1", 16'(bus.gpin_clean), 16'h00A4);
    step();
    chk("byp_e2", 16'(bus.gpin_clean), 16'h00A4);
    step();
    chk("byp_e3_clean", 16'(bus.gpin_clean), 16'h00A5);
    chk("byp_e3_edges", {bus.gpin_rise, bus.gpin_fall}, 16'h0100);
    step();
    chk("byp_e4_edges", {bus.gpin_rise, bus.gpin_fall}, 16'h0000);

    // Filtered latency, N=5: raw[3] 1->0 appears at edge 7.
    bus.cfg_filter_en = 1'b1;
    bus.cfg_stable_cycles = 8'd5;
    bus.gpin_raw = 8'hAD;
    repeat (10) step();
    chk("flt_setup", 16'(bus.gpin_clean), 16'h00AD);
    bus.gpin_raw = 8'hA5;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk("flt_wait_clean", 16'(bus.gpin_clean), 16'h00AD);
      chk("flt_wait_fall", 16'(bus.gpin_fall), 16'h0000);
    end
    step();
    chk("flt_e7_clean", 16'(bus.gpin_clean), 16'h00A5);
    chk("flt_e7_edges", {bus.gpin_rise, bus.gpin_fall}, 16'h0008);
    step();
    chk("flt_e8_edges", {bus.gpin_rise, bus.gpin_fall}, 16'h0000);

    // Glitch rejection: raw[1] high for 3 cycles with N=5.
    bus.gpin_raw = 8'hA7;
    repeat (3) step();
    bus.gpin_raw = 8'hA5;
    for (int e = 0; e < 10; e++) begin
      step();
      chk("glitch_clean", 16'(bus.gpin_clean), 16'h00A5);
      chk("glitch_edges", {bus.gpin_rise, bus.gpin_fall}, 16'h0000);
    end

    // All pads toggle together, N=3: update at edge 5.
    bus.cfg_stable_cycles = 8'd3;
    bus.gpin_raw = 8'h5A;
    repeat (4) step();
    chk("multi_e4", 16'(bus.gpin_clean), 16'h00A5);
    step();
    chk("multi_e5_clean", 16'(bus.gpin_clean), 16'h005A);
    chk("multi_e5_edges", {bus.gpin_rise, bus.gpin_fall}, 16'h5AA5);
    step();
    chk("multi_e6_edges", {bus.gpin_rise, bus.gpin_fall}, 16'h0000);
    bus.gpin_raw = 8'hA5;
    repeat (8) step();
    chk("multi_restore", 16'(bus.gpin_clean), 16'h00A5);

    // Lower N from 10 to 2 after 4 qualifying cycles.
    bus.cfg_stable_cycles = 8'd10;
    bus.gpin_raw = 8'hB5;
    repeat (6) step();
    chk("nlow_pre", 16'(bus.gpin_clean), 16'h00A5);
    bus.cfg_stable_cycles = 8'd2;
    step();
    chk("nlow_clean", 16'(bus.gpin_clean), 16'h00B5);
    chk("nlow_edges", {bus.gpin_rise, bus.gpin_fall}, 16'h1000);

    // Clear filter enable mid-qualification.
    bus.cfg_stable_cycles = 8'd10;
    bus.gpin_raw = 8'hA5;
    repeat (6) step();
    chk("fdis_pre", 16'(bus.gpin_clean), 16'h00B5);
    bus.cfg_filter_en = 1'b0;
    step();
    chk("fdis_clean", 16'(bus.gpin_clean), 16'h00A5);
    chk("fdis_edges", {bus.gpin_rise, bus.gpin_fall}, 16'h0010);
    bus.cfg_filter_en = 1'b1;
    step();

    // N=0 behaves as N=1: raw[6] 0->1 at edge 3.
    bus.cfg_stable_cycles = 8'd0;
    bus.gpin_raw = 8'hE5;
    repeat (2) step();
    chk("n0_e2", 16'(bus.gpin_clean), 16'h00A5);
    step();
    chk("n0_e3_clean", 16'(bus.gpin_clean), 16'h00E5);
    chk("n0_e3_edges", {bus.gpin_rise, bus.gpin_fall}, 16'h4000);

    // Reset during qualification discards the partial count.
    bus.cfg_stable_cycles = 8'd10;
    bus.gpin_raw = 8'hE4;
    repeat (5) step();
    chk("rmid_pre", 16'(bus.gpin_clean), 16'h00E5);
    reset_n = 1'b0;
    step();
    chk("rmid_clean", 16'(bus.gpin_clean), 16'h00A5);
    chk("rmid_edges", {bus.gpin_rise, bus.gpin_fall}, 16'h0000);
    reset_n = 1'b1;
    repeat (11) step();
    chk("rmid_e11", 16'(bus.gpin_clean), 16'h00A5);
    step();
    chk("rmid_e12_clean", 16'(bus.gpin_clean), 16'h00E4);
    chk("rmid_e12_edges", {bus.gpin_rise, bus.gpin_fall}, 16'h4001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
